// File: rtl/leve_ifq.sv
// leve_ifq: instruction fetch queue. Issues boundary-aligned AXI INCR bursts from the fetch PC,
// buffers {PC, instruction} pairs for decode, and flushes/refetches on REDIRECT.
module leve_ifq #(
    parameter int                ADDR_W    = 64,
    parameter int                BURST_LEN = 8,
    parameter int                DEPTH     = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = 64'h8000_0000
) (
    input  logic              CLK,
    input  logic              RSTn,
    output logic              ARVALID,
    input  logic              ARREADY,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [1:0]        ARBURST,
    output logic [7:0]        ARLEN,
    input  logic              RVALID,
    output logic              RREADY,
    input  logic [31:0]       RDATA,
    input  logic              RLAST,
    input  logic              REDIRECT,
    input  logic [ADDR_W-1:0] REDIRECT_PC,
    output logic              INST_VALID,
    input  logic              INST_READY,
    output logic [31:0]       INST,
    output logic [ADDR_W-1:0] INST_PC
);
    localparam int OFF_W = $clog2(BURST_LEN) + 2;
    localparam int NB_W  = $clog2(BURST_LEN) + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [NB_W-1:0] BURST_C = NB_W'(BURST_LEN);
    localparam logic [CNT_W:0]  DEPTH_C = (CNT_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [7:0]        arlen_q, arlen_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d, resv_q, resv_d;
    logic              redir_pend_q, redir_pend_d;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [31:0]       inst_mem [DEPTH];

    logic [NB_W-1:0] nb;
    logic            space_ok, beat, ar_hs, push, pop;

    assign ARVALID    = (state_q == ADDR);
    assign RREADY     = (state_q == DATA) || (state_q == DRAIN);
    assign ARADDR     = araddr_q;
    assign ARLEN      = arlen_q;
    assign ARBURST    = 2'b01;
    assign INST_VALID = (count_q != '0);
    assign INST       = inst_mem[rd_ptr_q];
    assign INST_PC    = pc_mem[rd_ptr_q];

    assign beat  = RVALID && RREADY;
    assign ar_hs = ARVALID && ARREADY;
    assign push  = (state_q == DATA) && beat && !REDIRECT;
    assign pop   = INST_VALID && INST_READY && !REDIRECT;

    // Beats left before the next BURST_LEN*4-byte boundary, so a burst never straddles it.
    assign nb       = BURST_C - {1'b0, pc_q[OFF_W-1:2]};
    assign space_ok = ({1'b0, count_q} + {1'b0, resv_q} + (CNT_W+1)'(nb)) <= DEPTH_C;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        resv_d       = resv_q;
        redir_pend_d = redir_pend_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;

        unique case (state_q)
            IDLE: begin
                if (!REDIRECT && space_ok) begin
                    state_d  = ADDR;
                    araddr_d = pc_q;
                    arlen_d  = 8'(nb - 1'b1);
                    resv_d   = CNT_W'(nb);
                end
            end
            ADDR: begin
                // The address phase cannot be withdrawn, so a redirect here is remembered
                // and the returning burst is drained instead of queued.
                if (ar_hs) begin
                    state_d      = (redir_pend_q || REDIRECT) ? DRAIN : DATA;
                    redir_pend_d = 1'b0;
                end else if (REDIRECT) begin
                    redir_pend_d = 1'b1;
                end
            end
            DATA: begin
                if (beat) begin
                    pc_d   = pc_q + ADDR_W'(4);
                    resv_d = resv_q - 1'b1;
                    if (RLAST) state_d = IDLE;
                end
                if (REDIRECT && !(beat && RLAST)) state_d = DRAIN;
            end
            DRAIN: begin
                if (beat && RLAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;

        if (REDIRECT) begin
            pc_d     = REDIRECT_PC;
            resv_d   = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            araddr_q     <= '0;
            arlen_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            resv_q       <= '0;
            redir_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            resv_q       <= resv_d;
            redir_pend_q <= redir_pend_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= pc_q;
            inst_mem[wr_ptr_q] <= RDATA;
        end
    end

endmodule

// File: tb/tb_leve_ifq.sv
// Bench for leve_ifq: AXI read memory returning word = address, plus a queue-based model
// of the decode-visible instruction stream and of the expected burst addresses.
module tb_leve_ifq;
    localparam int          ADDR_W   = 64;
    localparam int          BL       = 8;
    localparam int          DEPTH    = 16;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        ARVALID, ARREADY, RVALID, RREADY, RLAST, REDIRECT, INST_VALID, INST_READY;
    logic [63:0] ARADDR, REDIRECT_PC, INST_PC;
    logic [1:0]  ARBURST;
    logic [7:0]  ARLEN;
    logic [31:0] RDATA, INST;

    always #5 CLK = ~CLK;

    leve_ifq #(.ADDR_W(ADDR_W), .BURST_LEN(BL), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARBURST(ARBURST), .ARLEN(ARLEN),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RLAST(RLAST),
        .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
        .INST_VALID(INST_VALID), .INST_READY(INST_READY), .INST(INST), .INST_PC(INST_PC)
    );

    typedef struct {
        logic [63:0] addr;
        bit          last;
        bit          stale;
    } beat_t;

    beat_t       mem_q[$];
    logic [63:0] fifo_q[$];
    logic [63:0] pop_pc[$];
    int          pop_cyc[$];
    logic [63:0] exp_fetch, ar_addr0, last_ar_addr, first_ar_addr;
    logic [7:0]  ar_len0, last_ar_len, first_ar_len;
    bit          ar_seen, stale_ar, last_r_hs;
    int          n_vec, n_err, cyc, n_ar, n_beats, n_pop, first_beat_cyc, rv_pct;

    function automatic logic [7:0] exp_len(input logic [63:0] a);
        int nb;
        nb = BL - int'((a >> 2) % 64'(BL));
        return 8'(nb - 1);
    endfunction

    task automatic reset_model();
        mem_q.delete(); fifo_q.delete(); pop_pc.delete(); pop_cyc.delete();
        exp_fetch = RESET_PC; ar_seen = 0; stale_ar = 0; last_r_hs = 0;
        n_ar = 0; n_beats = 0; n_pop = 0; first_beat_cyc = -1;
        RVALID = 0; RLAST = 0; RDATA = '0; REDIRECT = 0;
    endtask

    task automatic do_reset();
        RSTn = 0;
        reset_model();
        repeat (3) @(negedge CLK);
        RSTn = 1;
    endtask

    // One clock: score what the coming edge will sample, advance, then drive the memory side.
    task automatic cycle();
        bit          ar_hs, r_hs, pop, redir;
        beat_t       b;
        logic [63:0] hd;
        ar_hs = ARVALID && ARREADY;
        r_hs  = RVALID && RREADY;
        pop   = INST_VALID && INST_READY;
        redir = REDIRECT;

        n_vec++;
        if (INST_VALID !== (fifo_q.size() != 0)) begin
            n_err++; $display("FAIL inst_valid cyc %0d: got %b want %b", cyc, INST_VALID, fifo_q.size() != 0);
        end
        if (mem_q.size() != 0) begin
            n_vec++;
            if (RREADY !== 1'b1) begin n_err++; $display("FAIL rready_mid_burst cyc %0d: got %b want 1", cyc, RREADY); end
        end
        if (ARVALID === 1'b1) begin
            if (!ar_seen) begin
                n_vec += 4;
                if (ARADDR !== exp_fetch) begin n_err++; $display("FAIL araddr: got %h want %h", ARADDR, exp_fetch); end
                if (ARLEN !== exp_len(exp_fetch)) begin n_err++; $display("FAIL arlen: got %0d want %0d", ARLEN, exp_len(exp_fetch)); end
                if (ARBURST !== 2'b01) begin n_err++; $display("FAIL arburst: got %b want 01", ARBURST); end
                if (fifo_q.size() + int'(ARLEN) + 1 > DEPTH) begin
                    n_err++; $display("FAIL ar_space: queued %0d + beats %0d exceeds %0d", fifo_q.size(), int'(ARLEN) + 1, DEPTH);
                end
                ar_seen = 1; ar_addr0 = ARADDR; ar_len0 = ARLEN;
                n_ar++; last_ar_addr = ARADDR; last_ar_len = ARLEN;
                if (n_ar == 1) begin first_ar_addr = ARADDR; first_ar_len = ARLEN; end
                exp_fetch = exp_fetch + 64'(4 * (int'(exp_len(exp_fetch)) + 1));
            end else begin
                n_vec++;
                if (ARADDR !== ar_addr0 || ARLEN !== ar_len0) begin
                    n_err++; $display("FAIL ar_stable: got %h/%0d want %h/%0d", ARADDR, ARLEN, ar_addr0, ar_len0);
                end
            end
        end
        if (pop && !redir && fifo_q.size() != 0) begin
            hd = fifo_q.pop_front();
            n_vec += 2;
            if (INST_PC !== hd) begin n_err++; $display("FAIL inst_pc: got %h want %h", INST_PC, hd); end
            if (INST !== hd[31:0]) begin n_err++; $display("FAIL inst: got %h want %h", INST, hd[31:0]); end
            pop_pc.push_back(INST_PC); pop_cyc.push_back(cyc); n_pop++;
        end
        if (r_hs && mem_q.size() != 0) begin
            b = mem_q.pop_front();
            n_beats++;
            if (first_beat_cyc < 0) first_beat_cyc = cyc;
            if (!b.stale && !redir) fifo_q.push_back(b.addr);
        end
        if (ar_hs) begin
            for (int i = 0; i <= int'(ar_len0); i++)
                mem_q.push_back('{addr: ar_addr0 + 64'(4 * i), last: (i == int'(ar_len0)), stale: (stale_ar || redir)});
            stale_ar = 0; ar_seen = 0;
        end
        if (redir) begin
            fifo_q.delete();
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            exp_fetch = REDIRECT_PC;
            if (ARVALID === 1'b1 && !ar_hs) stale_ar = 1;
        end
        last_r_hs = r_hs;

        @(posedge CLK);
        @(negedge CLK);
        cyc++;
        REDIRECT = 0;
        if (!(RVALID && !last_r_hs)) begin
            if (mem_q.size() != 0 && $urandom_range(99) < rv_pct) begin
                RVALID = 1; RDATA = mem_q[0].addr[31:0]; RLAST = mem_q[0].last;
            end else begin
                RVALID = 0; RLAST = 0;
            end
        end
    endtask

    task automatic test_reset();
        RSTn = 0;
        reset_model();
        repeat (2) @(negedge CLK);
        n_vec += 6;
        if (ARVALID !== 1'b0)    begin n_err++; $display("FAIL rst_arvalid: got %b want 0", ARVALID); end
        if (RREADY !== 1'b0)     begin n_err++; $display("FAIL rst_rready: got %b want 0", RREADY); end
        if (INST_VALID !== 1'b0) begin n_err++; $display("FAIL rst_inst_valid: got %b want 0", INST_VALID); end
        if (ARLEN !== 8'd0)      begin n_err++; $display("FAIL rst_arlen: got %0d want 0", ARLEN); end
        if (ARADDR !== 64'd0)    begin n_err++; $display("FAIL rst_araddr: got %h want 0", ARADDR); end
        if (ARBURST !== 2'b01)   begin n_err++; $display("FAIL rst_arburst: got %b want 01", ARBURST); end
        RSTn = 1;
        ARREADY = 0;
        cycle();
        n_vec += 2;
        if (ARVALID !== 1'b1)   begin n_err++; $display("FAIL post_rst_arvalid: got %b want 1", ARVALID); end
        if (ARADDR !== RESET_PC) begin n_err++; $display("FAIL post_rst_araddr: got %h want %h", ARADDR, RESET_PC); end
    endtask

    task automatic test_basic();
        do_reset();
        ARREADY = 1; INST_READY = 1; rv_pct = 100;
        repeat (40) cycle();
        n_vec += 3;
        if (first_ar_addr !== 64'h8000_0000) begin n_err++; $display("FAIL first_araddr: got %h want 80000000", first_ar_addr); end
        if (first_ar_len !== 8'd7) begin n_err++; $display("FAIL first_arlen: got %0d want 7", first_ar_len); end
        if (pop_cyc.size() < 8) begin
            n_err++; $display("FAIL basic_pops: got %0d want >= 8", pop_cyc.size());
        end else begin
            n_vec += 3;
            if (pop_cyc[0] != first_beat_cyc + 1) begin n_err++; $display("FAIL first_pop_latency: got cyc %0d want %0d", pop_cyc[0], first_beat_cyc + 1); end
            if (pop_cyc[7] - pop_cyc[0] != 7) begin n_err++; $display("FAIL pop_rate: got %0d cycles want 7", pop_cyc[7] - pop_cyc[0]); end
            if (pop_pc[7] !== 64'h8000_001C) begin n_err++; $display("FAIL eighth_pc: got %h want 8000001c", pop_pc[7]); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ARREADY = 1; INST_READY = 0; rv_pct = 100;
        repeat (60) cycle();
        n_vec += 2;
        if (n_ar != 2) begin n_err++; $display("FAIL bp_two_bursts: got %0d want 2", n_ar); end
        if (INST_VALID !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %b want 1", INST_VALID); end
        INST_READY = 1;
        repeat (8) cycle();
        INST_READY = 0;
        n_vec += 2;
        if (n_pop != 8) begin n_err++; $display("FAIL bp_pops: got %0d want 8", n_pop); end
        if (n_ar != 2) begin n_err++; $display("FAIL bp_early_ar: got %0d want 2", n_ar); end
        repeat (30) cycle();
        n_vec += 2;
        if (n_ar != 3) begin n_err++; $display("FAIL bp_third_ar: got %0d want 3", n_ar); end
        if (last_ar_addr !== 64'h8000_0040) begin n_err++; $display("FAIL bp_third_addr: got %h want 80000040", last_ar_addr); end
    endtask

    task automatic test_redirect_data();
        int k;
        do_reset();
        ARREADY = 1; INST_READY = 0; rv_pct = 100;
        k = 0;
        while (n_beats < 3 && k < 30) begin cycle(); k++; end
        REDIRECT = 1; REDIRECT_PC = 64'h8000_1008;
        cycle();
        n_vec++;
        if (INST_VALID !== 1'b0) begin n_err++; $display("FAIL rd_flush_valid: got %b want 0", INST_VALID); end
        k = 0;
        while (n_ar < 2 && k < 40) begin cycle(); k++; end
        n_vec += 3;
        if (n_ar < 2) begin n_err++; $display("FAIL rd_ar_timeout: got %0d ARs want 2", n_ar); end
        if (last_ar_addr !== 64'h8000_1008) begin n_err++; $display("FAIL rd_araddr: got %h want 80001008", last_ar_addr); end
        if (last_ar_len !== 8'd5) begin n_err++; $display("FAIL rd_arlen: got %0d want 5", last_ar_len); end
        INST_READY = 1;
        k = 0;
        while (n_pop < 1 && k < 40) begin cycle(); k++; end
        n_vec++;
        if (n_pop < 1) begin n_err++; $display("FAIL rd_pop_timeout: got 0 pops want 1"); end
        else begin
            n_vec++;
            if (pop_pc[0] !== 64'h8000_1008) begin n_err++; $display("FAIL rd_first_pc: got %h want 80001008", pop_pc[0]); end
        end
    endtask

    task automatic test_redirect_addr();
        int          k;
        logic [63:0] rpc;
        do_reset();
        ARREADY = 0; INST_READY = 1; rv_pct = 100;
        k = 0;
        while (ARVALID !== 1'b1 && k < 10) begin cycle(); k++; end
        rpc = {$urandom(), $urandom()} & ~64'h3;
        REDIRECT = 1; REDIRECT_PC = rpc;
        cycle();
        repeat (3) cycle();
        n_vec += 3;
        if (ARVALID !== 1'b1) begin n_err++; $display("FAIL ra_arvalid: got %b want 1", ARVALID); end
        if (ARADDR !== RESET_PC) begin n_err++; $display("FAIL ra_old_addr: got %h want %h", ARADDR, RESET_PC); end
        if (ARLEN !== 8'd7) begin n_err++; $display("FAIL ra_old_len: got %0d want 7", ARLEN); end
        ARREADY = 1;
        k = 0;
        while (n_ar < 2 && k < 40) begin cycle(); k++; end
        n_vec += 2;
        if (last_ar_addr !== rpc) begin n_err++; $display("FAIL ra_new_addr: got %h want %h", last_ar_addr, rpc); end
        if (n_pop != 0) begin n_err++; $display("FAIL ra_drained: got %0d pops want 0", n_pop); end
        k = 0;
        while (n_pop < 1 && k < 40) begin cycle(); k++; end
        n_vec++;
        if (n_pop < 1) begin n_err++; $display("FAIL ra_pop_timeout: got 0 pops want 1"); end
        else begin
            n_vec++;
            if (pop_pc[0] !== rpc) begin n_err++; $display("FAIL ra_first_pc: got %h want %h", pop_pc[0], rpc); end
        end
    endtask

    task automatic test_redirect_pop();
        int k, p;
        do_reset();
        ARREADY = 1; INST_READY = 0; rv_pct = 100;
        k = 0;
        while (INST_VALID !== 1'b1 && k < 20) begin cycle(); k++; end
        cycle();
        INST_READY = 1; REDIRECT = 1; REDIRECT_PC = 64'h8000_2000;
        p = n_pop;
        cycle();
        n_vec++;
        if (INST_VALID !== 1'b0) begin n_err++; $display("FAIL rp_valid: got %b want 0", INST_VALID); end
        k = 0;
        while (n_pop <= p && k < 40) begin cycle(); k++; end
        n_vec++;
        if (n_pop <= p) begin n_err++; $display("FAIL rp_pop_timeout: got %0d pops want > %0d", n_pop, p); end
        else begin
            n_vec++;
            if (pop_pc[p] !== 64'h8000_2000) begin n_err++; $display("FAIL rp_next_pc: got %h want 80002000", pop_pc[p]); end
        end
    endtask

    task automatic test_random();
        do_reset();
        rv_pct = 60;
        for (int i = 0; i < 3000; i++) begin
            ARREADY    = ($urandom_range(3) != 0);
            INST_READY = ($urandom_range(2) != 0);
            if ($urandom_range(49) == 0) begin
                REDIRECT = 1;
                case ($urandom_range(2))
                    0:       REDIRECT_PC = {$urandom(), $urandom()} & ~64'h3;
                    1:       REDIRECT_PC = 64'hFFFF_FFFF_FFFF_FFE0 + 64'(4 * $urandom_range(7));
                    default: REDIRECT_PC = RESET_PC + 64'(4 * $urandom_range(63));
                endcase
            end
            cycle();
        end
        ARREADY = 1; INST_READY = 1;
        repeat (60) cycle();
        n_vec++;
        if (n_pop < 50) begin n_err++; $display("FAIL rand_progress: got %0d pops want >= 50", n_pop); end
    endtask

    task automatic test_reset_async();
        int k;
        do_reset();
        ARREADY = 1; INST_READY = 0; rv_pct = 100;
        k = 0;
        while (n_beats < 2 && k < 20) begin cycle(); k++; end
        #2 RSTn = 0;
        #1;
        n_vec += 5;
        if (ARVALID !== 1'b0)    begin n_err++; $display("FAIL ar_async_arvalid: got %b want 0", ARVALID); end
        if (RREADY !== 1'b0)     begin n_err++; $display("FAIL ar_async_rready: got %b want 0", RREADY); end
        if (INST_VALID !== 1'b0) begin n_err++; $display("FAIL ar_async_inst_valid: got %b want 0", INST_VALID); end
        if (ARADDR !== 64'd0)    begin n_err++; $display("FAIL ar_async_araddr: got %h want 0", ARADDR); end
        if (ARLEN !== 8'd0)      begin n_err++; $display("FAIL ar_async_arlen: got %0d want 0", ARLEN); end
        reset_model();
        repeat (2) @(negedge CLK);
        RSTn = 1;
        k = 0;
        while (n_ar < 1 && k < 10) begin cycle(); k++; end
        n_vec++;
        if (last_ar_addr !== RESET_PC || n_ar < 1) begin
            n_err++; $display("FAIL ar_restart: got %h (%0d ARs) want %h", last_ar_addr, n_ar, RESET_PC);
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; rv_pct = 100;
        RSTn = 0; ARREADY = 0; INST_READY = 0; REDIRECT = 0; REDIRECT_PC = '0;
        RVALID = 0; RLAST = 0; RDATA = '0;
        last_ar_addr = '0; first_ar_addr = '0; last_ar_len = '0; first_ar_len = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_data();
        test_redirect_addr();
        test_redirect_pop();
        test_random();
        test_reset_async();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
